// File: rtl/wm_cycle_controller.sv
// Washing-machine sequencing FSM: drives the phase timer state bus and
// decodes actuator enables. Optional watchdog enabled by WM_WATCHDOG_EN.
module wm_cycle_controller #(
    parameter int MIN_DWELL      = 1,
    parameter int CNT_W          = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       cancel,
    input  logic       door_closed,
    input  logic       sig_full,
    input  logic       sig_temperature,
    input  logic       sig_completed,
    output logic [2:0] state,
    output logic       door_lock,
    output logic       water_valve,
    output logic       heater,
    output logic       motor_on,
    output logic       motor_fast,
    output logic       drain_valve,
    output logic       done,
    output logic       fault
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_FILL  = 3'd2;
    localparam logic [2:0] S_HEAT  = 3'd3;
    localparam logic [2:0] S_WASH  = 3'd4;
    localparam logic [2:0] S_RINSE = 3'd5;
    localparam logic [2:0] S_SPIN  = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam logic [CNT_W-1:0] DWELL   = CNT_W'(MIN_DWELL);
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

`ifdef WM_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] phase_cnt;
    logic             fault_q;
    logic             fault_d;
    logic             phase_flag;
    logic             timed;
    logic             dwell_ok;
    logic             timeout;

    // Completion flag that the current timed phase is waiting on.
    always_comb begin
        phase_flag = 1'b0;
        timed      = 1'b0;
        case (state_q)
            S_FILL: begin
                phase_flag = sig_full;
                timed      = 1'b1;
            end
            S_HEAT: begin
                phase_flag = sig_temperature;
                timed      = 1'b1;
            end
            S_WASH, S_RINSE, S_SPIN: begin
                phase_flag = sig_completed;
                timed      = 1'b1;
            end
            default: begin
                phase_flag = 1'b0;
                timed      = 1'b0;
            end
        endcase
    end

    assign dwell_ok = (phase_cnt >= DWELL);
    assign timeout  = WD_EN && timed && !phase_flag && (phase_cnt >= TMO);

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CHECK;
                    fault_d = 1'b0;
                end
            end
            S_CHECK: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else if (door_closed) begin
                    state_d = S_FILL;
                end
            end
            S_FILL, S_HEAT, S_WASH, S_RINSE, S_SPIN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else if (!door_closed || timeout) begin
                    state_d = S_IDLE;
                    fault_d = 1'b1;
                end else if (dwell_ok && phase_flag) begin
                    // Phase encodings are consecutive, SPIN+1 is DONE.
                    state_d = state_q + 3'd1;
                end
            end
            S_DONE: begin
                if (!door_closed) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            fault_q   <= 1'b0;
            phase_cnt <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            if (state_d != state_q) begin
                phase_cnt <= '0;
            end else if (phase_cnt != CNT_MAX) begin
                phase_cnt <= phase_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        door_lock   = 1'b0;
        water_valve = 1'b0;
        heater      = 1'b0;
        motor_on    = 1'b0;
        motor_fast  = 1'b0;
        drain_valve = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_CHECK: door_lock = 1'b1;
            S_FILL: begin
                door_lock   = 1'b1;
                water_valve = 1'b1;
            end
            S_HEAT: begin
                door_lock = 1'b1;
                heater    = 1'b1;
            end
            S_WASH: begin
                door_lock = 1'b1;
                motor_on  = 1'b1;
            end
            S_RINSE: begin
                door_lock   = 1'b1;
                motor_on    = 1'b1;
                drain_valve = 1'b1;
            end
            S_SPIN: begin
                door_lock   = 1'b1;
                motor_on    = 1'b1;
                motor_fast  = 1'b1;
                drain_valve = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: begin
                door_lock = 1'b0;
            end
        endcase
    end

    assign state = state_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_wm_cycle_controller.sv
// Bench for wm_cycle_controller: vector table through a scoreboard
// queue, plus async-reset and long-wait sequences.
module tb_wm_cycle_controller;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic       cancel;
    logic       door_closed;
    logic       sig_full;
    logic       sig_temperature;
    logic       sig_completed;
    logic [2:0] state;
    logic       door_lock;
    logic       water_valve;
    logic       heater;
    logic       motor_on;
    logic       motor_fast;
    logic       drain_valve;
    logic       done;
    logic       fault;

    wm_cycle_controller dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .cancel          (cancel),
        .door_closed     (door_closed),
        .sig_full        (sig_full),
        .sig_temperature (sig_temperature),
        .sig_completed   (sig_completed),
        .state           (state),
        .door_lock       (door_lock),
        .water_valve     (water_valve),
        .heater          (heater),
        .motor_on        (motor_on),
        .motor_fast      (motor_fast),
        .drain_valve     (drain_valve),
        .done            (done),
        .fault           (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // inputs packed as {start, cancel, door_closed, full, temp, completed}
    typedef struct packed {
        logic [5:0] in;
        logic [2:0] st;
        logic       flt;
    } vec_t;

    vec_t        vecs[$];
    logic [10:0] sb[$];
    int          errors = 0;
    int          checks = 0;

    wire logic [10:0] actv = {state, door_lock, water_valve, heater,
                              motor_on, motor_fast, drain_valve, done, fault};

    function automatic logic [10:0] model(logic [2:0] s, logic f);
        logic lk;
        logic mo;
        lk = (s >= 3'd1) && (s <= 3'd6);
        mo = (s >= 3'd4) && (s <= 3'd6);
        return {s, lk, s == 3'd2, s == 3'd3, mo, s == 3'd6,
                (s == 3'd5) || (s == 3'd6), s == 3'd7, f};
    endfunction

    function automatic void add(logic [5:0] in, logic [2:0] st, logic flt);
        vec_t v;
        v.in  = in;
        v.st  = st;
        v.flt = flt;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [10:0] act, logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(logic [5:0] in);
        {start, cancel, door_closed, sig_full, sig_temperature, sig_completed} = in;
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        drive(6'b000000);
        #1;
        check("reset_state", actv, 11'd0);

        // full cycle, flags raised 3 cycles into each phase
        add(6'b101000, 1, 0);
        add(6'b001000, 2, 0);
        for (int i = 0; i < 3; i++) add(6'b001000, 2, 0);
        add(6'b001100, 3, 0);
        for (int i = 0; i < 3; i++) add(6'b001000, 3, 0);
        add(6'b001010, 4, 0);
        for (int i = 0; i < 3; i++) add(6'b001000, 4, 0);
        add(6'b001001, 5, 0);
        for (int i = 0; i < 3; i++) add(6'b001000, 5, 0);
        add(6'b001001, 6, 0);
        for (int i = 0; i < 3; i++) add(6'b001000, 6, 0);
        add(6'b001001, 7, 0);
        add(6'b001000, 7, 0);
        add(6'b000000, 0, 0);
        add(6'b001000, 0, 0);
        // stale flags held from phase entry, start held throughout
        add(6'b101000, 1, 0);
        add(6'b101000, 2, 0);
        add(6'b101100, 2, 0);
        add(6'b101100, 3, 0);
        add(6'b101010, 3, 0);
        add(6'b101010, 4, 0);
        add(6'b101001, 4, 0);
        add(6'b101001, 5, 0);
        add(6'b101001, 5, 0);
        add(6'b101001, 6, 0);
        add(6'b101001, 6, 0);
        add(6'b101001, 7, 0);
        add(6'b101001, 7, 0);
        add(6'b100001, 0, 0);
        add(6'b101000, 1, 0);
        // door opened in WASH, then restart clears fault
        add(6'b001000, 2, 0);
        add(6'b001100, 2, 0);
        add(6'b001100, 3, 0);
        add(6'b001010, 3, 0);
        add(6'b001010, 4, 0);
        add(6'b000000, 0, 1);
        add(6'b010000, 0, 1);
        add(6'b000000, 0, 1);
        add(6'b100000, 1, 0);
        add(6'b000000, 1, 0);
        add(6'b001000, 2, 0);
        // cancel and door open together in HEAT
        add(6'b001100, 2, 0);
        add(6'b001100, 3, 0);
        add(6'b010000, 0, 0);
        // cancel ignored in DONE
        add(6'b101111, 1, 0);
        add(6'b001111, 2, 0);
        add(6'b001111, 2, 0);
        add(6'b001111, 3, 0);
        add(6'b001111, 3, 0);
        add(6'b001111, 4, 0);
        add(6'b001111, 4, 0);
        add(6'b001111, 5, 0);
        add(6'b001111, 5, 0);
        add(6'b001111, 6, 0);
        add(6'b001111, 6, 0);
        add(6'b001111, 7, 0);
        add(6'b011000, 7, 0);
        add(6'b000000, 0, 0);

        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            logic [10:0] e;
            @(negedge clock);
            drive(vecs[i].in);
            sb.push_back(model(vecs[i].st, vecs[i].flt));
            @(posedge clock);
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d", i), actv, e);
        end

        // reach SPIN, then assert reset between edges
        @(negedge clock);
        drive(6'b101111);
        n = 0;
        while (state != 3'd6 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("reach_spin", actv, model(3'd6, 1'b0));
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset", actv, 11'd0);
        @(negedge clock);
        drive(6'b000000);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("post_reset_idle", actv, 11'd0);

        // FILL with no sig_full
        @(negedge clock);
        drive(6'b101000);
        @(negedge clock);
        drive(6'b001000);
        @(posedge clock);
        #1;
        check("fill_entry", actv, model(3'd2, 1'b0));
        n = 0;
        for (int i = 0; i < 110; i++) begin
            @(posedge clock);
            #1;
            if (state == 3'd2) n++;
        end
`ifdef WM_WATCHDOG_EN
        check("watchdog_abort", actv, model(3'd0, 1'b1));
`else
        check("fill_hold", 11'(n), 11'd110);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wm_cycle_controller.md
Name: wm_cycle_controller

Overview:
- Main washing-machine sequencing FSM.
- Sits directly upstream of the phase timer: drives the 3-bit `state` bus that the timer counts on, and consumes the timer's `sig_full`, `sig_temperature` and `sig_completed` level flags.
- Decodes the state into actuator enables (door lock, water valve, heater, motor, drain) and a user-visible done/fault status.

Parameters:
- MIN_DWELL, 1, minimum cycles the FSM stays in a timed phase (states 2–6) before a timer flag may advance it.
- CNT_W, 4, width of the internal phase cycle counter; the counter saturates at 2^CNT_W-1.
- TIMEOUT_CYCLES, 15, watchdog limit per timed phase; used only with WM_WATCHDOG_EN.

Ports:
- clock  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  user start request, level.
- cancel  in  1  user abort, level.
- door_closed  in  1  door sensor, 1 = closed.
- sig_full  in  1  timer flag: tub full.
- sig_temperature  in  1  timer flag: water at temperature.
- sig_completed  in  1  timer flag: wash, rinse or spin phase complete.
- state  out  3  current state encoding, sent to the timer.
- door_lock  out  1  door latch engaged.
- water_valve  out  1  inlet valve open.
- heater  out  1  heater on.
- motor_on  out  1  drum motor enabled.
- motor_fast  out  1  spin speed select, valid only with motor_on.
- drain_valve  out  1  drain pump on.
- done  out  1  cycle finished.
- fault  out  1  cycle aborted by door open (or by watchdog when WM_WATCHDOG_EN is defined).

Behaviour:
- Reset and register style:
  - Reset is asynchronous active-low.
  - On reset: state=0 (IDLE), all outputs 0, phase counter 0, fault 0.
  - Reset asserted mid-cycle forces IDLE immediately.
- State encoding (fixed, shared with the timer): 0 IDLE, 1 CHECK_DOOR, 2 FILL_WATER, 3 HEAT_WATER, 4 WASH, 5 RINSE, 6 SPIN, 7 DONE.
- Outputs are a Moore decode of the state register, so they change on the same edge as `state`:
  - door_lock = 1 in states 1–6.
  - water_valve = 1 in state 2.
  - heater = 1 in state 3.
  - motor_on = 1 in states 4–6.
  - motor_fast = 1 in state 6.
  - drain_valve = 1 in states 5 and 6.
  - done = 1 in state 7.
- Phase counter:
  - Cleared on every state change, otherwise incremented, saturating.
  - A timed state (2–6) advances only when phase_cnt >= MIN_DWELL and its flag is 1. This guards against stale flag levels.
- Transitions, one per clock edge:
  - IDLE -> CHECK_DOOR when start=1. Entering CHECK_DOOR clears fault.
  - CHECK_DOOR -> FILL_WATER when door_closed=1; otherwise waits indefinitely.
  - FILL_WATER -> HEAT_WATER on sig_full.
  - HEAT_WATER -> WASH on sig_temperature.
  - WASH -> RINSE on sig_completed.
  - RINSE -> SPIN on sig_completed.
  - SPIN -> DONE on sig_completed.
  - DONE -> IDLE when door_closed=0, i.e. the user opens the door.
- Priority within states 1–6, highest first:
  1. cancel=1 -> IDLE, fault unchanged, done=0.
  2. door_closed=0 in states 2–6 -> IDLE with fault=1.
  3. Normal advance.
- Cancel in IDLE or DONE is ignored.
- start held high through the whole cycle does not restart it from DONE. Re-start requires passing through IDLE.
- fault is sticky until the next IDLE->CHECK_DOOR transition.
- Latency: start sampled high at edge N gives state=1 after edge N; with the door already closed, state=2 after edge N+1.

Optional Feature:
- Macro: WM_WATCHDOG_EN.
- Defined: in states 2–6, if phase_cnt reaches TIMEOUT_CYCLES without the phase flag, the FSM goes to IDLE with fault=1 on the next edge. Priority is below cancel and door-open, above normal advance; the counter width must hold TIMEOUT_CYCLES.
- Not defined: no timeout; a timed phase waits indefinitely for its flag.

Test Plan:
- Reset mid-SPIN (state=6), reset_n low -> state=0 and all outputs 0 asynchronously, before the next clock edge.
- Full cycle, door closed, start pulsed, each flag raised 3 cycles after phase entry -> state sequence 0,1,2,3,4,5,6,7; in state 6 door_lock=1, motor_fast=1, drain_valve=1; done=1 in state 7; door_closed=0 -> state 0.
- Stale flag: sig_completed held 1 on entry to RINSE with MIN_DWELL=1 -> RINSE lasts exactly 2 cycles (dwell, then advance), never skipped.
- Door opened in WASH -> next edge state=0, fault=1, motor_on=0; start again -> fault=0 on entry to CHECK_DOOR.
- cancel and door_closed=0 asserted together in HEAT_WATER -> state=0 with fault unchanged (cancel wins).
- WM_WATCHDOG_EN defined, TIMEOUT_CYCLES=15, sig_full never asserted -> state leaves 2 for 0 with fault=1 after 15 cycles in FILL_WATER. Without the macro, state stays 2 for at least 100 cycles.
